// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: IR fields, ALU flag, memory handshake and control strobes
// shared between the sequencer (master) and the datapath (slave).
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       illegal;
    logic       bus_err;
    logic [2:0] state;
    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
               alu_src, mem_to_reg, alu_op, illegal, bus_err, state
    );
    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
               alu_src, mem_to_reg, alu_op, illegal, bus_err, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I-subset core,
// one shared memory port with req/ready handshake and a wait-cycle timeout.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input logic clk,
    input logic rst_n,
    multicycle_ctrl_if.master bus
);
    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_MEMADDR = 3'd3;
    localparam logic [2:0] S_MEM     = 3'd4;
    localparam logic [2:0] S_WB      = 3'd5;
    localparam logic [2:0] S_BRANCH  = 3'd6;
    localparam logic [2:0] S_TRAP    = 3'd7;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    logic [2:0] st, nxt, dec;
    logic [CNT_W-1:0] cnt;
    logic run, illegal_q, bus_err_q;
    logic is_r, is_i, is_lw, is_sw, is_br;
    logic waiting, ready, timeout;
    logic unused;
    assign unused = bus.funct7_5;
    assign is_r  = bus.opcode == OP_R;
    assign is_i  = bus.opcode == OP_I;
    assign is_lw = bus.opcode == OP_LW;
    assign is_sw = bus.opcode == OP_SW;
    assign is_br = bus.opcode == OP_BR;
    assign dec = (is_r || is_i) ? S_EXEC :
                 ((is_lw || is_sw) && bus.funct3 == 3'b010) ? S_MEMADDR :
                 (is_br && bus.funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
    // run holds FETCH quiet for the first cycle after reset release
    assign waiting = (st == S_FETCH && run) || st == S_MEM;
    assign ready   = waiting && bus.mem_ready;
    assign timeout = waiting && !bus.mem_ready && cnt == CNT_W'(TIMEOUT - 1);
    always_comb begin
        case (st)
            S_FETCH:   nxt = ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
            S_DECODE:  nxt = dec;
            S_EXEC:    nxt = S_WB;
            S_MEMADDR: nxt = S_MEM;
            S_MEM:     nxt = ready ? (is_sw ? S_FETCH : S_WB) : timeout ? S_TRAP : S_MEM;
            S_WB:      nxt = S_FETCH;
            S_BRANCH:  nxt = S_FETCH;
            default:   nxt = S_TRAP;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            st        <= S_FETCH;
            cnt       <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            run       <= 1'b1;
            st        <= nxt;
            cnt       <= (waiting && !bus.mem_ready) ? cnt + 1'b1 : '0;
            illegal_q <= illegal_q | (st == S_DECODE && dec == S_TRAP);
            bus_err_q <= bus_err_q | timeout;
        end
    end
    assign bus.state      = st;
    assign bus.illegal    = illegal_q;
    assign bus.bus_err    = bus_err_q;
    assign bus.mem_req    = (st == S_FETCH && run) || st == S_MEM;
    assign bus.mem_we     = st == S_MEM && is_sw;
    assign bus.ir_write   = st == S_FETCH && ready;
    assign bus.pc_write   = (st == S_MEM && ready && is_sw) || st == S_WB || st == S_BRANCH;
    assign bus.pc_src     = st == S_BRANCH && (bus.funct3[0] ? !bus.zero : bus.zero);
    assign bus.reg_write  = st == S_WB;
    assign bus.alu_src    = (st == S_EXEC && is_i) || st == S_MEMADDR || st == S_MEM;
    assign bus.mem_to_reg = st == S_WB && is_lw;
    assign bus.alu_op     = st == S_EXEC ? 2'b10 : st == S_BRANCH ? 2'b01 : 2'b00;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; each driven cycle queues its expected
// state/strobe vector, compared on the following falling edge.
module tb_multicycle_ctrl;
    localparam logic [11:0] REQ = 12'h800, WE = 12'h400, IRW = 12'h200, PCW = 12'h100;
    localparam logic [11:0] PCS = 12'h080, RW = 12'h040, AS = 12'h020, MTR = 12'h010;
    localparam logic [11:0] AOP_F = 12'h008, AOP_S = 12'h004, ILL = 12'h002, BE = 12'h001;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    logic [14:0] exp_q[$];
    string tag_q[$];
    logic [14:0] act_v;
    multicycle_ctrl_if bus();
    multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    assign act_v = {bus.state, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write,
                    bus.pc_src, bus.reg_write, bus.alu_src, bus.mem_to_reg,
                    bus.alu_op, bus.illegal, bus.bus_err};
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask
    always @(negedge clk)
        if (exp_q.size() != 0) check(tag_q.pop_front(), {17'd0, act_v}, {17'd0, exp_q.pop_front()});
    task automatic step(input logic rdy, input logic z, input logic [2:0] st,
                        input logic [11:0] c, input string tag);
        bus.mem_ready = rdy;
        bus.zero = z;
        exp_q.push_back({st, c});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_state", {17'd0, act_v}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 3'd0, 12'h000, "run0");
    endtask
    task automatic load(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bus.opcode = op;
        bus.funct3 = f3;
        bus.funct7_5 = f7;
        step(1'b1, 1'b0, 3'd0, REQ | IRW, "fetch");
        step(1'b1, 1'b0, 3'd1, 12'h000, "decode");
    endtask
    task automatic branch(input logic [2:0] f3, input logic z, input logic pcs);
        load(7'b1100011, f3, 1'b0);
        step(1'b0, z, 3'd6, AOP_S | PCW | (pcs ? PCS : 12'h000), "branch");
    endtask
    initial begin
        bus.opcode = '0;
        bus.funct3 = '0;
        bus.funct7_5 = 1'b0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        load(7'b0110011, 3'b000, 1'b0);
        step(1'b1, 1'b0, 3'd2, AOP_F, "add_exec");
        step(1'b1, 1'b0, 3'd5, RW | PCW, "add_wb");
        load(7'b0110011, 3'b000, 1'b1);
        step(1'b0, 1'b0, 3'd2, AOP_F, "sub_exec");
        step(1'b0, 1'b0, 3'd5, RW | PCW, "sub_wb");
        load(7'b0010011, 3'b111, 1'b0);
        step(1'b1, 1'b0, 3'd2, AOP_F | AS, "addi_exec");
        step(1'b1, 1'b0, 3'd5, RW | PCW, "addi_wb");
        load(7'b0000011, 3'b010, 1'b0);
        step(1'b1, 1'b0, 3'd3, AS, "lw_addr");
        step(1'b0, 1'b0, 3'd4, REQ | AS, "lw_wait0");
        step(1'b0, 1'b0, 3'd4, REQ | AS, "lw_wait1");
        step(1'b1, 1'b0, 3'd4, REQ | AS, "lw_mem");
        step(1'b0, 1'b0, 3'd5, RW | MTR | PCW, "lw_wb");
        load(7'b0100011, 3'b010, 1'b0);
        step(1'b0, 1'b0, 3'd3, AS, "sw_addr");
        step(1'b0, 1'b0, 3'd4, REQ | WE | AS, "sw_wait");
        step(1'b1, 1'b0, 3'd4, REQ | WE | AS | PCW, "sw_mem");
        branch(3'b000, 1'b1, 1'b1);
        branch(3'b000, 1'b0, 1'b0);
        branch(3'b001, 1'b0, 1'b1);
        branch(3'b001, 1'b1, 1'b0);
        bus.opcode = 7'b0110011;
        bus.funct3 = 3'b000;
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 3'd0, REQ, "fetch_wait");
        step(1'b1, 1'b0, 3'd0, REQ | IRW, "fetch_last_ok");
        step(1'b0, 1'b0, 3'd1, 12'h000, "decode_after_wait");
        step(1'b0, 1'b0, 3'd2, AOP_F, "exec_after_wait");
        step(1'b0, 1'b0, 3'd5, RW | PCW, "wb_after_wait");
        load(7'b1111111, 3'b000, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'($urandom_range(0, 1)), 1'b0, 3'd7, ILL, "illegal_trap");
        do_reset();
        load(7'b0000011, 3'b000, 1'b0);
        step(1'b1, 1'b0, 3'd7, ILL, "lw_bad_f3");
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 3'd0, REQ, "fetch_to");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd7, BE, "bus_err_trap");
        do_reset();
        load(7'b0100011, 3'b010, 1'b0);
        step(1'b0, 1'b0, 3'd3, AS, "sw2_addr");
        step(1'b0, 1'b0, 3'd4, REQ | WE | AS, "sw2_wait");
        #2;
        check("mid_mem_req_we", {30'd0, bus.mem_req, bus.mem_we}, 32'd3);
        do_reset();
        load(7'b0110011, 3'b000, 1'b0);
        step(1'b1, 1'b0, 3'd2, AOP_F, "add2_exec");
        step(1'b1, 1'b0, 3'd5, RW | PCW, "add2_wb");
        step(1'b1, 1'b0, 3'd0, REQ | IRW, "add2_next_fetch");
        check("drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
